mmio_timer: RTL and testbench
=============================

Name: mmio_timer

Overview:
- Memory-mapped timer/compare peripheral on the CPU data-memory bus.
- Acts as a responder on the same interface the CPU drives toward ram: addr, wr_sig, wr_data and rd_data.
- Decodes a 32-byte window at BASE_ADDR and holds control, prescale, count, compare and status registers.
- Raises irq on compare match. Outside the window it drives rd_data=0, so the top level can OR it with ram's rd_data.

Parameters:
- BASE_ADDR, 32'h0000_1000, word-aligned base of the 32-byte register window; bits [4:0] must be 0.
- PRESCALE_W, 16, width of the prescale divisor register and the prescale counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- addr  input  32  byte address from the CPU (the mem_addr bus).
- wr_sig  input  1  write strobe (mem_wr_sig); a write commits on the rising edge while high.
- wr_data  input  32  write data (mem_wr_data).
- rd_data  output  32  read data. Combinational from addr and the current registers; 0 when addr is outside the window.
- sel  output  1  high when addr[31:5]==BASE_ADDR[31:5].
- irq  output  1  CTRL.IRQ_EN & STATUS.MATCH.

Behaviour:
- Register map (offset = addr[4:0]; addr[1:0] ignored):
  - 0x00 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [3] ONE_SHOT. Bits [31:4] read 0.
  - 0x04 PRESCALE: [PRESCALE_W-1:0] divisor-1; upper bits read 0.
  - 0x08 COUNT: read/write.
  - 0x0C COMPARE: read/write.
  - 0x10 STATUS: [0] MATCH, [1] OVERFLOW. Both sticky, write-1-to-clear.
  - 0x14–0x1C: read 0; writes ignored.
- Writes take effect only when sel & wr_sig. There are no byte enables; writes are full-word.
- Read latency is zero: rd_data reflects register values as of the last rising edge, same cycle as addr.
- Reset (reset_n low at an edge):
  - All registers 0, including the prescale counter.
  - irq=0; rd_data=0 for every in-window address.
  - Reset overrides any concurrent write or tick.
- Prescaler:
  - pcnt increments each cycle while EN=1.
  - When EN=1 and pcnt==PRESCALE, a tick occurs and pcnt returns to 0.
  - PRESCALE=0 gives a tick every enabled cycle.
  - When EN=0, pcnt holds at 0.
  - Any write to CTRL or PRESCALE clears pcnt.
- On a tick, nxt = COUNT+1 (modulo 2^32):
  - If COUNT==32'hFFFF_FFFF: OVERFLOW<=1.
  - If nxt==COMPARE: MATCH<=1; COUNT<=0 if AUTO_RELOAD else nxt; EN<=0 if ONE_SHOT.
  - Otherwise: COUNT<=nxt.
- Simultaneous events:
  - A CPU write to COUNT in a tick cycle: the write wins and the tick increment is discarded.
  - A CPU write to CTRL in a tick cycle that also clears EN via ONE_SHOT: the written CTRL value wins.
  - A W1C write to STATUS in the same cycle a flag is set: the set wins and the flag stays 1.
- Writing COMPARE equal to the current COUNT does not set MATCH; only a tick can set it.
- irq is a function of registers only, so it is glitch-free. It rises in the cycle after the tick edge that sets MATCH and clears after a W1C of MATCH or IRQ_EN=0.
- Reset mid-count returns everything to 0; EN must be rewritten to restart.

Test Plan:
- Reset: hold reset_n=0 for 2 edges, then read 0x00–0x1C -> all 0, irq=0; read at addr=0x0000_2000 -> rd_data=0, sel=0.
- Basic match: write COMPARE=5, PRESCALE=0, then CTRL=0x5 (EN|IRQ_EN) -> COUNT reads 1,2,3,4,5 on the 5 following edges; MATCH=1 and irq=1 after the 5th edge; COUNT=6 after the 6th. Write STATUS=1 -> MATCH=0, irq=0.
- Prescale: PRESCALE=3, COMPARE=0xFFFF, EN=1 -> COUNT increments once per 4 cycles; after 40 cycles COUNT=10.
- Auto-reload and one-shot:
  - CTRL=0x3, COMPARE=3, PRESCALE=0 -> COUNT sequence 1,2,0,1,2,0; MATCH set at the first 0.
  - CTRL=0x9 -> COUNT stops at 3 and CTRL reads 0x8 after the match.
- Overflow: write COUNT=0xFFFF_FFFF, COMPARE=0x10, CTRL=0x1 -> next edge COUNT=0, STATUS=0x2. Write STATUS=0x2 -> STATUS=0.
- Collisions:
  - Write COUNT=100 on a tick edge -> COUNT=100, not old+1.
  - W1C STATUS=1 on the edge that sets MATCH -> MATCH stays 1.
  - Write to 0x0000_2008 -> no register changes.

Source files
------------

// File: rtl/mmio_timer.sv
// Memory-mapped timer/compare peripheral on the CPU data bus.
// A prescaled counter sets MATCH and OVERFLOW flags; irq = IRQ_EN & MATCH.
module mmio_timer #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] addr,
   input  logic        wr_sig,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        sel,
   output logic        irq
);

   typedef enum logic [2:0] {
      REG_CTRL     = 3'd0,
      REG_PRESCALE = 3'd1,
      REG_COUNT    = 3'd2,
      REG_COMPARE  = 3'd3,
      REG_STATUS   = 3'd4
   } reg_e;

   logic [3:0]            ctrl;      // {ONE_SHOT, IRQ_EN, AUTO_RELOAD, EN}
   logic [PRESCALE_W-1:0] prescale;
   logic [PRESCALE_W-1:0] pcnt;
   logic [31:0]           count;
   logic [31:0]           compare;
   logic [1:0]            status;    // {OVERFLOW, MATCH}

   reg_e        idx;
   logic        wr_en;
   logic        wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
   logic        tick, hit, ovf;
   logic [31:0] nxt;
   logic [1:0]  w1c;

   assign idx         = reg_e'(addr[4:2]);
   assign sel         = (addr[31:5] == BASE_ADDR[31:5]);
   assign wr_en       = sel & wr_sig;
   assign wr_ctrl     = wr_en && (idx == REG_CTRL);
   assign wr_prescale = wr_en && (idx == REG_PRESCALE);
   assign wr_count    = wr_en && (idx == REG_COUNT);
   assign wr_compare  = wr_en && (idx == REG_COMPARE);
   assign wr_status   = wr_en && (idx == REG_STATUS);

   assign tick = ctrl[0] && (pcnt == prescale);
   assign nxt  = count + 32'd1;
   assign hit  = tick && (nxt == compare);
   assign ovf  = tick && (count == '1);
   assign w1c  = wr_status ? wr_data[1:0] : 2'b00;
   assign irq  = ctrl[2] & status[0];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ctrl     <= '0;
         prescale <= '0;
         pcnt     <= '0;
         count    <= '0;
         compare  <= '0;
         status   <= '0;
      end else begin
         if (wr_ctrl || wr_prescale || !ctrl[0] || tick)
            pcnt <= '0;
         else
            pcnt <= pcnt + 1'b1;

         // A CPU write to CTRL takes precedence over the one-shot EN clear.
         if (wr_ctrl)
            ctrl <= wr_data[3:0];
         else if (hit && ctrl[3])
            ctrl[0] <= 1'b0;

         if (wr_prescale)
            prescale <= wr_data[PRESCALE_W-1:0];

         if (wr_count)
            count <= wr_data;
         else if (tick)
            count <= (hit && ctrl[1]) ? '0 : nxt;

         if (wr_compare)
            compare <= wr_data;

         // Setting a flag outranks a simultaneous write-1-to-clear.
         status <= (status & ~w1c) | {ovf, hit};
      end
   end

   always_comb begin
      rd_data = '0;
      if (sel) begin
         case (idx)
            REG_CTRL:     rd_data = {28'd0, ctrl};
            REG_PRESCALE: rd_data = 32'(prescale);
            REG_COUNT:    rd_data = count;
            REG_COMPARE:  rd_data = compare;
            REG_STATUS:   rd_data = {30'd0, status};
            default:      rd_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer with hand-computed expectations.
module tb_mmio_timer;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam logic [31:0] A_CTRL = BASE + 32'h00;
   localparam logic [31:0] A_PRE  = BASE + 32'h04;
   localparam logic [31:0] A_CNT  = BASE + 32'h08;
   localparam logic [31:0] A_CMP  = BASE + 32'h0C;
   localparam logic [31:0] A_STAT = BASE + 32'h10;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] addr = '0;
   logic        wr_sig = 1'b0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data;
   logic        sel;
   logic        irq;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .addr(addr), .wr_sig(wr_sig),
      .wr_data(wr_data), .rd_data(rd_data), .sel(sel), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; wr_data = d; wr_sig = 1'b1;
      @(posedge clk); #1;
      wr_sig = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      addr = a; wr_sig = 1'b0;
      #1;
      check(tag, rd_data, exp);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      // reset
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 8; i++)
         rd_chk($sformatf("reset_reg%0d", i), BASE + 32'(i * 4), 32'd0);
      check("reset_irq", {31'd0, irq}, 32'd0);
      rd_chk("oow_rd", 32'h0000_2000, 32'd0);
      check("oow_sel", {31'd0, sel}, 32'd0);
      step();

      // basic match
      wr(A_CMP, 32'd5);
      wr(A_PRE, 32'd0);
      wr(A_CTRL, 32'h5);
      for (int i = 1; i <= 5; i++) begin
         step();
         rd_chk($sformatf("basic_cnt%0d", i), A_CNT, 32'(i));
      end
      rd_chk("basic_match", A_STAT, 32'h1);
      check("basic_irq", {31'd0, irq}, 32'd1);
      step();
      rd_chk("basic_cnt6", A_CNT, 32'd6);
      wr(A_STAT, 32'h1);
      rd_chk("basic_w1c", A_STAT, 32'h0);
      check("basic_irq_clr", {31'd0, irq}, 32'd0);

      // prescale
      wr(A_CTRL, 32'h0);
      wr(A_CNT, 32'd0);
      wr(A_STAT, 32'h3);
      wr(A_PRE, 32'd3);
      wr(A_CMP, 32'h0000_FFFF);
      wr(A_CTRL, 32'h1);
      repeat (3) step();
      rd_chk("pre_cnt_3cyc", A_CNT, 32'd0);
      step();
      rd_chk("pre_cnt_4cyc", A_CNT, 32'd1);
      repeat (36) step();
      rd_chk("pre_cnt_40cyc", A_CNT, 32'd10);

      // auto-reload
      wr(A_CTRL, 32'h0);
      wr(A_PRE, 32'd0);
      wr(A_CNT, 32'd0);
      wr(A_CMP, 32'd3);
      wr(A_STAT, 32'h3);
      wr(A_CTRL, 32'h3);
      begin
         logic [31:0] seq [6] = '{32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 32'd0};
         for (int i = 0; i < 6; i++) begin
            step();
            rd_chk($sformatf("ar_cnt%0d", i), A_CNT, seq[i]);
            if (i == 1) rd_chk("ar_nomatch_yet", A_STAT, 32'h0);
            if (i == 2) rd_chk("ar_match", A_STAT, 32'h1);
         end
      end

      // one-shot
      wr(A_CTRL, 32'h0);
      wr(A_CNT, 32'd0);
      wr(A_STAT, 32'h3);
      wr(A_CTRL, 32'h9);
      for (int i = 1; i <= 3; i++) begin
         step();
         rd_chk($sformatf("os_cnt%0d", i), A_CNT, 32'(i));
      end
      rd_chk("os_ctrl", A_CTRL, 32'h8);
      repeat (2) step();
      rd_chk("os_cnt_hold", A_CNT, 32'd3);

      // overflow
      wr(A_STAT, 32'h3);
      wr(A_CNT, 32'hFFFF_FFFF);
      wr(A_CMP, 32'h10);
      wr(A_CTRL, 32'h1);
      step();
      rd_chk("ovf_cnt", A_CNT, 32'd0);
      rd_chk("ovf_stat", A_STAT, 32'h2);
      wr(A_STAT, 32'h2);
      rd_chk("ovf_w1c", A_STAT, 32'h0);

      // write COUNT on a tick edge
      wr(A_CNT, 32'd100);
      rd_chk("col_cnt_wr", A_CNT, 32'd100);
      step();
      rd_chk("col_cnt_next", A_CNT, 32'd101);

      // W1C on the edge that sets MATCH
      wr(A_CTRL, 32'h0);
      wr(A_CNT, 32'd0);
      wr(A_CMP, 32'd2);
      wr(A_STAT, 32'h3);
      wr(A_CTRL, 32'h5);
      step();
      wr(A_STAT, 32'h1);
      rd_chk("col_set_wins", A_STAT, 32'h1);
      check("col_irq", {31'd0, irq}, 32'd1);
      wr(A_CTRL, 32'h1);
      check("irq_en_off", {31'd0, irq}, 32'd0);

      // COMPARE written equal to COUNT does not match
      wr(A_CTRL, 32'h0);
      wr(A_STAT, 32'h3);
      wr(A_CNT, 32'd7);
      wr(A_CMP, 32'd7);
      rd_chk("cmp_eq_nomatch", A_STAT, 32'h0);

      // out-of-window and reserved writes
      wr(32'h0000_2008, 32'h1234);
      rd_chk("oow_wr_cnt", A_CNT, 32'd7);
      wr(BASE + 32'h14, 32'hFFFF_FFFF);
      rd_chk("rsvd_rd", BASE + 32'h14, 32'd0);
      wr(A_CTRL, 32'hFFFF_FFF0);
      rd_chk("ctrl_upper", A_CTRL, 32'd0);
      wr(A_PRE, 32'hFFFF_FFFF);
      rd_chk("pre_upper", A_PRE, 32'h0000_FFFF);
      wr(A_PRE, 32'd0);

      // reset mid-count
      wr(A_CTRL, 32'h5);
      repeat (3) step();
      rd_chk("mid_cnt", A_CNT, 32'd10);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      rd_chk("rst_cnt", A_CNT, 32'd0);
      rd_chk("rst_ctrl", A_CTRL, 32'd0);
      rd_chk("rst_cmp", A_CMP, 32'd0);
      step();
      rd_chk("rst_stays", A_CNT, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
